hysteresis_threshold: RTL and testbench
=======================================

HYSTERESIS_THRESHOLD -- requirements
Module: hysteresis_threshold

Interface
REQ-001 The block SHALL have the parameter NBIT_INPUT, default 12, giving the magnitude width and matching the NMS output width.
REQ-002 The block SHALL have the parameter IMG_WIDTH, default 640, giving pixels per line, minimum 3.
REQ-003 The block SHALL have the parameter IMG_HEIGHT, default 480, giving lines per frame, minimum 3.
REQ-004 The block SHALL have the port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have the port i_valid, input, 1 bit: i_pixel is valid this cycle.
REQ-007 The block SHALL have the port i_sof, input, 1 bit: this beat is pixel (0,0) of a frame.
REQ-008 The block SHALL have the port i_pixel, input, NBIT_INPUT bits: suppressed magnitude from NMS, in raster order.
REQ-009 The block SHALL have the port i_th_low, input, NBIT_INPUT bits: weak threshold.
REQ-010 The block SHALL have the port i_th_high, input, NBIT_INPUT bits: strong threshold.
REQ-011 The block SHALL have the port o_ready, output, 1 bit: an input beat is accepted when i_valid and o_ready are both high.
REQ-012 The block SHALL have the port o_valid, output, 1 bit: o_edge is valid this cycle.
REQ-013 The block SHALL have the port o_sof, output, 1 bit: this output beat is pixel (0,0).
REQ-014 The block SHALL have the port o_edge, output, 1 bit: final edge decision, 1 = edge.

Function
REQ-015 Each accepted pixel SHALL be classified as follows: STRONG if pixel >= th_high; else WEAK if pixel >= th_low; else NONE.
REQ-016 Thresholds SHALL be latched on the accepted i_sof beat and held constant for the whole frame; if th_low > th_high, th_low SHALL be treated as equal to th_high.
REQ-017 Classes SHALL be stored as 2-bit codes in two line buffers of IMG_WIDTH entries and combined with the current input to form a 3x3 class window.
REQ-018 For window centre (r,c), o_edge SHALL be 1 iff the centre is STRONG, or the centre is WEAK and at least one of its 8 neighbours is STRONG; otherwise o_edge SHALL be 0.
REQ-019 Border pixels (r=0, r=IMG_HEIGHT-1, c=0, c=IMG_WIDTH-1) SHALL output o_edge=0 regardless of class; the window SHALL NOT wrap across lines.
REQ-020 The output for (r,c) SHALL be registered and presented with o_valid=1 in the cycle after the acceptance (real or phantom) of linear index r*IMG_WIDTH+c+IMG_WIDTH+1.
REQ-021 Exactly IMG_WIDTH*IMG_HEIGHT output beats SHALL be produced per frame, in raster order, with o_sof=1 only on the (0,0) beat; no output backpressure exists.
REQ-022 The block SHALL implement an FSM with three states. IDLE: o_ready=1; beats without i_sof are discarded; an accepted i_sof beat moves to RUN. RUN: o_ready=1; the last frame pixel moves to FLUSH. FLUSH: o_ready=0; the block generates IMG_WIDTH+1 phantom pixels of class NONE, one per cycle, then returns to IDLE.
REQ-023 An accepted i_sof in RUN SHALL abort the current frame without emitting its remaining outputs, reset the row/column counters and restart with this beat as (0,0).
REQ-024 In RUN, i_valid=0 cycles SHALL stall the pipeline; no output is produced and no state advances.

Reset
REQ-025 While i_rst_n=0: the FSM SHALL be in IDLE; counters and the output register SHALL be 0; o_valid=0, o_sof=0, o_edge=0, o_ready=0.
REQ-026 o_ready SHALL go high on the first clock edge after reset deassertion; a mid-frame reset SHALL discard the frame entirely, and line buffer contents need not be cleared.

Structure
REQ-027 The shared package canny_pkg SHALL hold the class type (NONE=2'b00, WEAK=2'b01, STRONG=2'b10) and the default image-size constants.
REQ-028 The line buffer SHALL be a sub-module named class_line_buffer (depth IMG_WIDTH, 2-bit data, one read and one write per accepted beat), instantiated twice.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, th_low=20, th_high=100)
REQ-029 An all-zero frame SHALL produce 48 beats, all o_edge=0, with o_sof only on the first beat and o_ready low for exactly 9 FLUSH cycles.
REQ-030 A single pixel of 150 at (2,3), with all others 0, SHALL produce o_edge=1 only at (2,3); the first output SHALL appear 1 cycle after input index 9 is accepted.
REQ-031 A pixel of 50 at (2,3) with 150 at (3,4) SHALL give edges at (2,3) and (3,4); the same 50 with no strong neighbour SHALL give no edge at (2,3).
REQ-032 A value of 150 at (0,0) and at (2,7) SHALL produce o_edge=0 at both (border), and a WEAK at (3,0) SHALL not be promoted by a STRONG at (2,7) (no wrap).
REQ-033 A threshold change during a frame SHALL be ignored; th_low=200 with th_high=100 SHALL classify 150 as STRONG and 99 as NONE.
REQ-034 i_sof reasserted at pixel 20 of a frame SHALL start a new frame at that beat with 48 outputs; an i_rst_n pulse at pixel 30 SHALL produce no further outputs until the next i_sof.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and defaults for the Canny edge pipeline stages.
package canny_pkg;

    // Per-pixel classification carried through the hysteresis line buffers.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'b00,
        CLS_WEAK   = 2'b01,
        CLS_STRONG = 2'b10
    } class_t;

    // Hysteresis frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam int unsigned DEF_NBIT_INPUT = 12;
    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 480;

    // A strong centre is always an edge; a weak centre needs a strong neighbour.
    function automatic logic edge_decide(input class_t centre, input logic [7:0] nbr_strong);
        return (centre == CLS_STRONG) || ((centre == CLS_WEAK) && (|nbr_strong));
    endfunction

endpackage

// File: rtl/class_line_buffer.sv
// One image line of 2-bit pixel classes; read-before-write at the same address.
module class_line_buffer
    import canny_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_IMG_WIDTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  class_t        wdata,
    output class_t        rdata
);

    class_t mem [DEPTH];

    // Storage write; contents are never cleared, stale data is masked by border logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/hysteresis_threshold.sv
// Canny hysteresis stage: classifies pixels and promotes weak pixels touching a strong one.
module hysteresis_threshold
    import canny_pkg::*;
#(
    parameter int unsigned NBIT_INPUT = DEF_NBIT_INPUT,
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic [NBIT_INPUT-1:0] i_pixel,
    input  logic [NBIT_INPUT-1:0] i_th_low,
    input  logic [NBIT_INPUT-1:0] i_th_high,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic                  o_sof,
    output logic                  o_edge
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam int unsigned FW = $clog2(IMG_WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

    state_t                  state, state_nxt;
    logic                    accept, advance, restart, phantom, emit, primed, border;
    logic [CW-1:0]           in_col, out_col, lb_addr;
    logic [RW-1:0]           in_row, out_row;
    logic [FW-1:0]           flush_cnt;
    logic [NBIT_INPUT-1:0]   th_lo_q, th_hi_q, th_lo_use, th_hi_use;
    class_t                  cls_in, lb1_rd, lb2_rd, centre;
    class_t                  win [3][3];
    logic [7:0]              nbr_strong;

    assign accept = i_valid && o_ready;

    // Next-state and per-cycle pipeline control.
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        restart   = 1'b0;
        phantom   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && i_sof) begin
                    advance   = 1'b1;
                    restart   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    advance = 1'b1;
                    if (i_sof) begin
                        restart = 1'b1;
                    end else if ((in_row == ROW_LAST) && (in_col == COL_LAST)) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                advance = 1'b1;
                phantom = 1'b1;
                if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Classify the incoming beat; the sof beat uses the thresholds being latched with it.
    always_comb begin
        th_hi_use = th_hi_q;
        th_lo_use = th_lo_q;
        if (restart) begin
            th_hi_use = i_th_high;
            th_lo_use = (i_th_low > i_th_high) ? i_th_high : i_th_low;
        end
        cls_in = CLS_NONE;
        if (!phantom) begin
            if (i_pixel >= th_hi_use) begin
                cls_in = CLS_STRONG;
            end else if (i_pixel >= th_lo_use) begin
                cls_in = CLS_WEAK;
            end
        end
    end

    assign lb_addr = restart ? '0 : in_col;

    class_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk   (i_clk),
        .we    (advance),
        .addr  (lb_addr),
        .wdata (cls_in),
        .rdata (lb1_rd)
    );

    class_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
        .clk   (i_clk),
        .we    (advance),
        .addr  (lb_addr),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    // 3x3 class window; column 2 is refilled from the line buffers and the new beat.
    always_ff @(posedge i_clk) begin
        if (advance) begin
            for (int unsigned i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= cls_in;
        end
    end

    // The decision looks at the window as it will be after this beat shifts in,
    // so the centre is the current win[1][2] and the new column comes straight from the inputs.
    assign centre     = win[1][2];
    assign nbr_strong = {win[0][1] == CLS_STRONG, win[0][2] == CLS_STRONG, lb2_rd == CLS_STRONG,
                         win[1][1] == CLS_STRONG, lb1_rd == CLS_STRONG,
                         win[2][1] == CLS_STRONG, win[2][2] == CLS_STRONG, cls_in == CLS_STRONG};

    assign primed = (in_row != '0) && !((in_row == RW'(1)) && (in_col == '0));
    assign emit   = advance && !restart && (phantom || primed);
    assign border = (out_row == '0) || (out_row == ROW_LAST) || (out_col == '0) || (out_col == COL_LAST);

    // State, counters, latched thresholds and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_ready   <= 1'b0;
            o_valid   <= 1'b0;
            o_sof     <= 1'b0;
            o_edge    <= 1'b0;
            in_col    <= '0;
            in_row    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            flush_cnt <= '0;
            th_lo_q   <= '0;
            th_hi_q   <= '0;
        end else begin
            state   <= state_nxt;
            o_ready <= (state_nxt != ST_FLUSH);
            o_valid <= emit;
            o_sof   <= emit && (out_row == '0) && (out_col == '0);
            o_edge  <= emit && !border && edge_decide(centre, nbr_strong);

            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 1'b1 : '0;

            if (advance) begin
                if (restart) begin
                    in_col  <= CW'(1);
                    in_row  <= '0;
                    out_col <= '0;
                    out_row <= '0;
                    th_hi_q <= th_hi_use;
                    th_lo_q <= th_lo_use;
                end else begin
                    if (in_col == COL_LAST) begin
                        in_col <= '0;
                        in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                    end else begin
                        in_col <= in_col + 1'b1;
                    end
                end
            end

            if (emit) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hysteresis_threshold.sv
// Directed bench for hysteresis_threshold on an 8x6 image.
module tb_hysteresis_threshold;

    localparam int unsigned W = 8;
    localparam int unsigned H = 6;
    localparam int unsigned N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic [11:0] i_pixel = '0;
    logic [11:0] th_low = 12'd20;
    logic [11:0] th_high = 12'd100;
    logic        o_ready, o_valid, o_sof, o_edge;

    hysteresis_threshold #(
        .NBIT_INPUT (12),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .i_sof     (i_sof),
        .i_pixel   (i_pixel),
        .i_th_low  (th_low),
        .i_th_high (th_high),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_sof     (o_sof),
        .o_edge    (o_edge)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [11:0] img [N];

    // Output collector state.
    int          n_out, sof_cnt, beat, first_cyc, ready_low, acc9;
    logic        first_sof, counting;
    logic [47:0] edge_mask;
    logic [47:0] exp_mask;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            if (n_out == 0) begin
                first_cyc = cyc;
                first_sof = o_sof;
            end
            if (o_sof) begin
                sof_cnt++;
                beat = 0;
                edge_mask = '0;
            end
            if (beat < 48) edge_mask[beat] = o_edge;
            beat++;
            n_out++;
        end
        if (counting && !o_ready) ready_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        n_out = 0; sof_cnt = 0; beat = 0; first_cyc = -1; ready_low = 0;
        acc9 = -2; first_sof = 1'b0; counting = 1'b0; edge_mask = '0;
    endtask

    task automatic clear_img();
        for (int k = 0; k < int'(N); k++) img[k] = '0;
    endtask

    task automatic send_range(input int from, input int to, input bit sof_first, input int gap);
        int waits;
        for (int k = from; k <= to; k++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_sof   = sof_first && (k == from);
            i_pixel = img[k];
            waits = 0;
            while (!o_ready && waits < 50) begin
                @(negedge clk);
                waits++;
            end
            if (!o_ready) begin
                checks++; errors++;
                $display("FAIL ready_timeout got 0 exp 1 at index %0d", k);
            end
            @(posedge clk);
            #1;
            if (k == 9) acc9 = cyc;
            i_valid = 1'b0;
            i_sof   = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic drain();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        clear_stats();
        repeat (3) @(negedge clk);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_valid); end
        checks++; if (o_sof !== 1'b0) begin errors++; $display("FAIL rst_sof got %b exp 0", o_sof); end
        checks++; if (o_edge !== 1'b0) begin errors++; $display("FAIL rst_edge got %b exp 0", o_edge); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %b exp 1", o_ready); end
    endtask

    task automatic test_zero_frame();
        clear_stats(); clear_img();
        counting = 1'b1;
        send_range(0, 47, 1, 0);
        drain();
        counting = 1'b0;
        checks++; if (n_out !== 48) begin errors++; $display("FAIL zero_count got %0d exp 48", n_out); end
        checks++; if (edge_mask !== 48'h0) begin errors++; $display("FAIL zero_mask got %h exp 0", edge_mask); end
        checks++; if (sof_cnt !== 1) begin errors++; $display("FAIL zero_sof_cnt got %0d exp 1", sof_cnt); end
        checks++; if (first_sof !== 1'b1) begin errors++; $display("FAIL zero_first_sof got %b exp 1", first_sof); end
        checks++; if (ready_low !== 9) begin errors++; $display("FAIL zero_flush_ready_low got %0d exp 9", ready_low); end
    endtask

    task automatic test_single_strong();
        clear_stats(); clear_img();
        img[19] = 12'd150;
        send_range(0, 47, 1, 0);
        drain();
        exp_mask = '0; exp_mask[19] = 1'b1;
        checks++; if (edge_mask !== exp_mask) begin errors++; $display("FAIL single_mask got %h exp %h", edge_mask, exp_mask); end
        checks++; if (first_cyc !== acc9) begin errors++; $display("FAIL single_latency got %0d exp %0d", first_cyc, acc9); end
        checks++; if (n_out !== 48) begin errors++; $display("FAIL single_count got %0d exp 48", n_out); end
    endtask

    task automatic test_weak_promote();
        clear_stats(); clear_img();
        img[19] = 12'd50; img[28] = 12'd150;
        send_range(0, 47, 1, 2);
        drain();
        exp_mask = '0; exp_mask[19] = 1'b1; exp_mask[28] = 1'b1;
        checks++; if (edge_mask !== exp_mask) begin errors++; $display("FAIL weak_mask got %h exp %h", edge_mask, exp_mask); end
        checks++; if (first_cyc !== acc9) begin errors++; $display("FAIL stall_latency got %0d exp %0d", first_cyc, acc9); end
        checks++; if (n_out !== 48) begin errors++; $display("FAIL stall_count got %0d exp 48", n_out); end
        clear_stats(); clear_img();
        img[19] = 12'd50;
        send_range(0, 47, 1, 0);
        drain();
        checks++; if (edge_mask !== 48'h0) begin errors++; $display("FAIL weak_alone_mask got %h exp 0", edge_mask); end
    endtask

    task automatic test_border();
        clear_stats(); clear_img();
        img[0] = 12'd150; img[23] = 12'd150; img[24] = 12'd50; img[30] = 12'd50;
        send_range(0, 47, 1, 0);
        drain();
        exp_mask = '0; exp_mask[30] = 1'b1;
        checks++; if (edge_mask !== exp_mask) begin errors++; $display("FAIL border_mask got %h exp %h", edge_mask, exp_mask); end
        checks++; if (n_out !== 48) begin errors++; $display("FAIL border_count got %0d exp 48", n_out); end
    endtask

    task automatic test_threshold();
        clear_stats(); clear_img();
        img[19] = 12'd50;
        send_range(0, 0, 1, 0);
        th_low = 12'd0; th_high = 12'd10;
        send_range(1, 47, 0, 0);
        drain();
        checks++; if (edge_mask !== 48'h0) begin errors++; $display("FAIL th_hold_mask got %h exp 0", edge_mask); end
        checks++; if (n_out !== 48) begin errors++; $display("FAIL th_hold_count got %0d exp 48", n_out); end
        clear_stats(); clear_img();
        th_low = 12'd200; th_high = 12'd100;
        img[19] = 12'd150; img[20] = 12'd99; img[36] = 12'd100;
        send_range(0, 47, 1, 0);
        drain();
        exp_mask = '0; exp_mask[19] = 1'b1; exp_mask[36] = 1'b1;
        checks++; if (edge_mask !== exp_mask) begin errors++; $display("FAIL th_swap_mask got %h exp %h", edge_mask, exp_mask); end
        checks++; if (n_out !== 48) begin errors++; $display("FAIL th_swap_count got %0d exp 48", n_out); end
        th_low = 12'd20; th_high = 12'd100;
    endtask

    task automatic test_abort();
        clear_stats(); clear_img();
        send_range(0, 19, 1, 0);
        img[19] = 12'd150;
        send_range(0, 47, 1, 0);
        drain();
        exp_mask = '0; exp_mask[19] = 1'b1;
        checks++; if (n_out !== 59) begin errors++; $display("FAIL abort_total got %0d exp 59", n_out); end
        checks++; if (sof_cnt !== 2) begin errors++; $display("FAIL abort_sof_cnt got %0d exp 2", sof_cnt); end
        checks++; if (beat !== 48) begin errors++; $display("FAIL abort_frame_len got %0d exp 48", beat); end
        checks++; if (edge_mask !== exp_mask) begin errors++; $display("FAIL abort_mask got %h exp %h", edge_mask, exp_mask); end
    endtask

    task automatic test_reset_mid();
        clear_stats(); clear_img();
        send_range(0, 29, 1, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", o_valid); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", o_ready); end
        checks++; if (n_out !== 21) begin errors++; $display("FAIL midrst_before got %0d exp 21", n_out); end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        send_range(30, 39, 0, 0);
        drain();
        checks++; if (n_out !== 21) begin errors++; $display("FAIL midrst_after got %0d exp 21", n_out); end
        send_range(0, 47, 1, 0);
        drain();
        checks++; if (n_out !== 69) begin errors++; $display("FAIL midrst_next_frame got %0d exp 69", n_out); end
        checks++; if (edge_mask !== 48'h0) begin errors++; $display("FAIL midrst_mask got %h exp 0", edge_mask); end
    endtask

    initial begin
        clear_stats();
        clear_img();
        test_reset();
        test_zero_frame();
        test_single_strong();
        test_weak_promote();
        test_border();
        test_threshold();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
